// File: rtl/nv_ram_pkg.sv
// Shared definitions for the parametrised 1R1W flop RAM family.
package nv_ram_pkg;

  // Ceiling log2, minimum 1 so a two-entry RAM still has a one-bit address.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Read-select encoding for the stage-2 data mux, listed in priority order.
  localparam logic [2:0] RD_SEL_BYP    = 3'd0;
  localparam logic [2:0] RD_SEL_ERR    = 3'd1;
  localparam logic [2:0] RD_SEL_FWD    = 3'd2;
  localparam logic [2:0] RD_SEL_UNINIT = 3'd3;
  localparam logic [2:0] RD_SEL_MEM    = 3'd4;

endpackage

// File: rtl/nv_ram_rwsthp_param_if.sv
// Read, write, bypass and status signals of one nv_ram_rwsthp_param instance.
interface nv_ram_rwsthp_param_if #(
  parameter int AW    = 5,
  parameter int WIDTH = 80
);
  logic [AW-1:0]    ra;
  logic             re;
  logic             ore;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic             rd_err;
  logic             rd_uninit;
  logic [AW-1:0]    wa;
  logic             we;
  logic [WIDTH-1:0] di;
  logic             wr_err;
  logic             byp_sel;
  logic [WIDTH-1:0] dbyp;
  logic [31:0]      pwrbus_ram_pd;

  modport master (
    output ra, re, ore, wa, we, di, byp_sel, dbyp, pwrbus_ram_pd,
    input  dout, dout_vld, rd_err, rd_uninit, wr_err
  );

  modport slave (
    input  ra, re, ore, wa, we, di, byp_sel, dbyp, pwrbus_ram_pd,
    output dout, dout_vld, rd_err, rd_uninit, wr_err
  );
endinterface

// File: rtl/nv_ram_vld_map.sv
// Per-entry written-valid bitmap: set on write, cleared only by reset.
module nv_ram_vld_map
  import nv_ram_pkg::*;
#(
  parameter  int DEPTH = 19,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic [AW-1:0] lkp_addr,
  output logic          lkp_vld
);

  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

  logic [DEPTH-1:0] map;

  // Mark an entry valid when it is written; the caller guarantees set_addr is in range.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map <= '0;
    end else if (set_en) begin
      map[set_addr] <= 1'b1;
    end
  end

  // Out-of-range lookups report not-valid rather than indexing past the map.
  assign lkp_vld = ({1'b0, lkp_addr} < DEPTH_W) ? map[lkp_addr] : 1'b0;

endmodule

// File: rtl/nv_ram_rwsthp_param.sv
// Parametrised 1R1W flop RAM: registered read address, output-register enable,
// bypass mux, written-valid tracking, optional write forwarding and error flags.
module nv_ram_rwsthp_param
  import nv_ram_pkg::*;
#(
  parameter  int DEPTH       = 19,
  parameter  int WIDTH       = 80,
  parameter  int FWD_EN      = 1,
  parameter  int UNINIT_ZERO = 1,
  localparam int AW          = clog2(DEPTH)
) (
  input  logic                    nvdla_core_clk,
  input  logic                    nvdla_core_rstn,
  nv_ram_rwsthp_param_if.slave    bus
);

  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ra_d;
  logic             rd_pend;
  logic             wa_ok;
  logic             ra_ok;
  logic             wr_set;
  logic             ra_vld;
  logic [2:0]       rd_sel;
  logic [WIDTH-1:0] rd_data;
  logic             unused_pwrbus;

  // The power-down bus has no functional effect on this model.
  assign unused_pwrbus = ^bus.pwrbus_ram_pd;

  assign wa_ok  = ({1'b0, bus.wa} < DEPTH_W);
  assign ra_ok  = ({1'b0, ra_d} < DEPTH_W);
  assign wr_set = bus.we & wa_ok;

  nv_ram_vld_map #(.DEPTH(DEPTH)) u_vld_map (
    .clk      (nvdla_core_clk),
    .rst_n    (nvdla_core_rstn),
    .set_en   (wr_set),
    .set_addr (bus.wa),
    .lkp_addr (ra_d),
    .lkp_vld  (ra_vld)
  );

  // Array write; out-of-range writes are dropped.
  // NOTE: the array has no reset; stale contents are hidden by the valid bitmap instead.
  always_ff @(posedge nvdla_core_clk) begin
    if (wr_set) begin
      mem[bus.wa] <= bus.di;
    end
  end

  // One-cycle pulse flagging a dropped out-of-range write.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_err_q_reset: bus.wr_err <= 1'b0;
    end else begin
      bus.wr_err <= bus.we & ~wa_ok;
    end
  end

  // Read stage 1: capture the address and note that a real read is pending.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      ra_d    <= '0;
      rd_pend <= 1'b0;
    end else if (bus.re) begin
      ra_d    <= bus.ra;
      rd_pend <= 1'b1;
    end else if (bus.ore) begin
      rd_pend <= 1'b0;
    end
  end

  // Read stage 2: prioritised source select and data mux.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    rd_sel  = RD_SEL_MEM;
    rd_data = '0;
    if (bus.byp_sel) begin
      rd_sel = RD_SEL_BYP;
    end else if (!ra_ok) begin
      rd_sel = RD_SEL_ERR;
    end else if ((FWD_EN != 0) && bus.we && (bus.wa == ra_d)) begin
      rd_sel = RD_SEL_FWD;
    end else if ((UNINIT_ZERO != 0) && !ra_vld) begin
      rd_sel = RD_SEL_UNINIT;
    end
    case (rd_sel)
      RD_SEL_BYP: rd_data = bus.dbyp;
      RD_SEL_FWD: rd_data = bus.di;
      RD_SEL_MEM: rd_data = mem[ra_d];
      default:    rd_data = '0;
    endcase
  end

  // Output stage: load data and status only when the output register is enabled.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      bus.dout      <= '0;
      bus.dout_vld  <= 1'b0;
      bus.rd_err    <= 1'b0;
      bus.rd_uninit <= 1'b0;
    end else if (bus.ore) begin
      bus.dout      <= rd_data;
      bus.dout_vld  <= rd_pend | bus.byp_sel;
      bus.rd_err    <= (rd_sel == RD_SEL_ERR) & ~bus.byp_sel;
      bus.rd_uninit <= (rd_sel == RD_SEL_UNINIT) & ~bus.byp_sel;
    end
  end

endmodule

// File: tb/tb_nv_ram_rwsthp_param.sv
// Directed bench: one instance with forwarding, one without, driven identically.
module tb_nv_ram_rwsthp_param;
  localparam int DEPTH = 19;
  localparam int WIDTH = 80;
  localparam int AW    = 5;

  logic             clk;
  logic             rstn;
  logic [AW-1:0]    ra, wa;
  logic             re, ore, we, byp_sel;
  logic [WIDTH-1:0] di, dbyp;

  int tests;
  int fails;

  nv_ram_rwsthp_param_if #(.AW(AW), .WIDTH(WIDTH)) bus_f ();
  nv_ram_rwsthp_param_if #(.AW(AW), .WIDTH(WIDTH)) bus_n ();

  assign bus_f.ra = ra;   assign bus_n.ra = ra;
  assign bus_f.re = re;   assign bus_n.re = re;
  assign bus_f.ore = ore; assign bus_n.ore = ore;
  assign bus_f.wa = wa;   assign bus_n.wa = wa;
  assign bus_f.we = we;   assign bus_n.we = we;
  assign bus_f.di = di;   assign bus_n.di = di;
  assign bus_f.byp_sel = byp_sel; assign bus_n.byp_sel = byp_sel;
  assign bus_f.dbyp = dbyp;       assign bus_n.dbyp = dbyp;
  assign bus_f.pwrbus_ram_pd = 32'h0;
  assign bus_n.pwrbus_ram_pd = 32'h0;

  nv_ram_rwsthp_param #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWD_EN(1), .UNINIT_ZERO(1)) dut_f (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .bus             (bus_f.slave)
  );

  nv_ram_rwsthp_param #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWD_EN(0), .UNINIT_ZERO(1)) dut_n (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .bus             (bus_n.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    re = 1'b0; ore = 1'b0; we = 1'b0; byp_sel = 1'b0;
    ra = '0; wa = '0; di = '0; dbyp = '0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    idle();
    rstn = 1'b0;
    tick(); tick();
    check("rst_dout",  bus_f.dout, 0);
    check("rst_vld",   bus_f.dout_vld, 0);
    check("rst_rderr", bus_f.rd_err, 0);
    check("rst_uninit", bus_f.rd_uninit, 0);
    check("rst_wrerr", bus_f.wr_err, 0);
    rstn = 1'b1;
    tick();

    // Read of a never-written entry returns zero and flags uninit.
    re = 1; ra = 3; tick();
    re = 0; ore = 1; tick();
    check("uninit_dout", bus_f.dout, 0);
    check("uninit_flag", bus_f.rd_uninit, 1);
    check("uninit_vld",  bus_f.dout_vld, 1);
    check("uninit_err",  bus_f.rd_err, 0);

    // Write then read back with two-cycle latency.
    idle(); we = 1; wa = 5; di = 80'hA5A5; tick();
    idle(); re = 1; ra = 5; tick();
    idle(); ore = 1; tick();
    check("wr_rd_dout",   bus_f.dout, 80'hA5A5);
    check("wr_rd_vld",    bus_f.dout_vld, 1);
    check("wr_rd_uninit", bus_f.rd_uninit, 0);

    // Forwarding: write to the address being captured in the ore cycle.
    idle(); we = 1; wa = 7; di = 1; tick();
    idle(); re = 1; ra = 7; tick();
    idle(); ore = 1; we = 1; wa = 7; di = 2; tick();
    check("fwd_on_dout",  bus_f.dout, 2);
    check("fwd_off_dout", bus_n.dout, 1);
    check("fwd_off_uninit", bus_n.rd_uninit, 0);
    // Simultaneous re and ore: capture uses old ra_d (7), rd_pend already cleared.
    idle(); re = 1; ra = 5; ore = 1; tick();
    check("fwd_off_later", bus_n.dout, 2);
    check("sim_old_ra_vld", bus_f.dout_vld, 0);
    idle(); ore = 1; tick();
    check("sim_new_ra_dout", bus_f.dout, 80'hA5A5);
    check("sim_new_ra_vld",  bus_f.dout_vld, 1);

    // Out-of-range write is dropped and pulses wr_err for one cycle.
    idle(); we = 1; wa = 20; di = 80'h77; tick();
    check("wrerr_pulse", bus_f.wr_err, 1);
    idle(); re = 1; ra = 1; tick();
    check("wrerr_clear", bus_f.wr_err, 0);
    idle(); ore = 1; tick();
    check("wrerr_nochg_dout",   bus_f.dout, 0);
    check("wrerr_nochg_uninit", bus_f.rd_uninit, 1);

    // Out-of-range read.
    idle(); re = 1; ra = 25; tick();
    idle(); ore = 1; tick();
    check("rderr_dout",   bus_f.dout, 0);
    check("rderr_flag",   bus_f.rd_err, 1);
    check("rderr_vld",    bus_f.dout_vld, 1);
    check("rderr_uninit", bus_f.rd_uninit, 0);

    // Bypass with no pending read, then hold, then a reload without a pending read.
    idle(); byp_sel = 1; dbyp = 80'hFF; ore = 1; tick();
    check("byp_dout", bus_f.dout, 80'hFF);
    check("byp_vld",  bus_f.dout_vld, 1);
    check("byp_err",  bus_f.rd_err, 0);
    idle(); tick();
    check("byp_hold", bus_f.dout, 80'hFF);
    idle(); ore = 1; tick();
    check("reload_vld", bus_f.dout_vld, 0);
    check("reload_err", bus_f.rd_err, 1);

    // Fill all entries with a reset part-way through.
    idle(); byp_sel = 1; dbyp = 80'hFF; ore = 1; tick();
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 10) begin
        idle();
        rstn = 1'b0;
        #1;
        check("midrst_dout", bus_f.dout, 0);
        check("midrst_vld",  bus_f.dout_vld, 0);
        tick();
        rstn = 1'b1;
      end
      idle(); we = 1; wa = i[AW-1:0]; di = WIDTH'(100 + i); tick();
    end
    idle(); re = 1; ra = 4; tick();
    idle(); ore = 1; tick();
    check("postrst_dout",   bus_f.dout, 0);
    check("postrst_uninit", bus_f.rd_uninit, 1);
    idle(); re = 1; ra = 12; tick();
    idle(); ore = 1; tick();
    check("postrst_wr_dout",   bus_n.dout, 112);
    check("postrst_wr_uninit", bus_n.rd_uninit, 0);

    idle();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nv_ram_rwsthp_param.md
Name: nv_ram_rwsthp_param

Overview:
Parametrised successor of the fixed-size 1R1W flop RAMs with registered read address, output-register enable and bypass mux. It adds an asynchronous reset on all control and output state, a per-entry written-valid bitmap, optional write-to-read forwarding, and a read-data valid strobe. It also flags out-of-range addresses. It drops into NVDLA datapath buffers in place of the fixed nv_ram_rwsthp_DxW instances.

Parameters:
DEPTH, 19, number of entries (2..1024).
WIDTH, 80, data width in bits.
AW, clog2(DEPTH), address width; derived localparam, not overridable.
FWD_EN, 1, 1 = a same-cycle write to the address being read is forwarded into dout.
UNINIT_ZERO, 1, 1 = reads of never-written entries return all-zero data.

Ports:
- nvdla_core_clk  in  1  clock. One clock domain.
- nvdla_core_rstn  in  1  reset. Asynchronous assert, active-low.
- ra  in  AW  read address, sampled when re=1.
- re  in  1  read enable; captures ra into ra_d.
- ore  in  1  output-register enable.
- dout  out  WIDTH  registered read data.
- dout_vld  out  1  registered; dout holds data from a real read.
- rd_err  out  1  registered; captured read address was >= DEPTH.
- rd_uninit  out  1  registered; captured entry was never written since reset.
- wa  in  AW  write address.
- we  in  1  write enable.
- di  in  WIDTH  write data.
- wr_err  out  1  registered pulse; write to wa >= DEPTH was dropped.
- byp_sel  in  1  selects dbyp into the output register.
- dbyp  in  WIDTH  bypass data.
- pwrbus_ram_pd  in  32  power-down bus; functionally ignored.

Behaviour:
- Reset values (rstn=0, asynchronous):
  - ra_d=0, rd_pend=0, vld_map=0.
  - dout=0, dout_vld=0, rd_err=0, rd_uninit=0, wr_err=0.
  - Array M is not reset. Stale contents are masked by vld_map when UNINIT_ZERO=1.
- Write, edge end of cycle T:
  - If we and wa<DEPTH: M[wa]<=di and vld_map[wa]<=1.
  - If we and wa>=DEPTH: no array or map update; wr_err<=1 for one cycle.
  - Otherwise wr_err<=0.
- Read stage 1, edge end of cycle T: if re, ra_d<=ra and rd_pend<=1; else if ore, rd_pend<=0; else hold.
- Read stage 2, combinational during cycle T+1, with priority:
  1. byp_sel -> dbyp.
  2. ra_d>=DEPTH -> 0, err=1.
  3. FWD_EN and we and wa==ra_d -> di.
  4. UNINIT_ZERO and !vld_map[ra_d] -> 0, uninit=1.
  5. Otherwise M[ra_d].
- Output stage, edge end of cycle T+1:
  - If ore: dout<=selected data; dout_vld<=rd_pend|byp_sel; rd_err<=err&!byp_sel; rd_uninit<=uninit&!byp_sel.
  - If !ore: all four outputs hold.
- Latency: re at T, ore at T+1 -> dout valid from T+2. With re and ore both held high, throughput is one read per cycle.
- Forwarding with FWD_EN=0: the capture returns the old M[ra_d] and vld_map state; the write still lands.
- re without a following ore: ra_d updates, dout holds.
- ore with rd_pend=0 and byp_sel=0: dout reloads M[ra_d] and dout_vld<=0.
- Reset mid-read: pending data is lost and dout_vld=0. Entries written before reset read as zero/uninit afterwards.
- Simultaneous re and ore: ore captures using the old ra_d, and ra_d takes the new ra.

Decomposition:
- Package nv_ram_pkg:
  - clog2 function.
  - Localparams for the read-select encoding (BYP, ERR, FWD, UNINIT, MEM).
- Sub-module nv_ram_vld_map (DEPTH):
  - Async-reset bitmap with set-on-write port and combinational lookup port.
  - Shared with future multi-port variants.

Test Plan:
- Reset, then re=1 ra=3, then ore=1 -> dout=0, rd_uninit=1, dout_vld=1, rd_err=0.
- Write wa=5 di=80'hA5A5; next cycle re ra=5; then ore -> dout=80'hA5A5, dout_vld=1, rd_uninit=0 at T+2.
- ra_d=7 with M[7]=1 and FWD_EN=1; in the ore cycle we wa=7 di=2 -> dout=2. Same sequence with FWD_EN=0 -> dout=1, and the next read of 7 returns 2.
- we wa=20 (DEPTH=19) -> wr_err pulses one cycle, no entry changes. re ra=25, ore -> dout=0, rd_err=1.
- byp_sel=1 dbyp=80'hFF with ore, no prior re -> dout=80'hFF, dout_vld=1, rd_err=0. ore=0 next cycle -> dout holds 80'hFF.
- Write entries 0..18, assert rstn=0 mid-stream for 1 cycle, then read entry 4 -> dout=0, rd_uninit=1. Outputs are 0 during reset.
